// File: rtl/dual_fetch.sv
// dual_fetch: two-wide instruction fetch stage. Fetches 8-byte blocks from
// instruction memory, presents up to two slot instructions with their PCs,
// follows decode-stage redirects and flushes on a mispredict, draining any
// request still outstanding in memory before restarting at the new PC.
module dual_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [63:0] imem_rdata,
   input  logic        is_stall,
   input  logic        depend,
   input  logic        pre_branch1,
   input  logic        pre_branch2,
   input  logic [31:0] predict_pc1,
   input  logic [31:0] predict_pc2,
   input  logic        fail,
   input  logic [31:0] fail_pc,
   output logic [31:0] ir1,
   output logic [31:0] ir2,
   output logic [31:0] IFpc1,
   output logic [31:0] IFpc2,
   output logic        is_jump1,
   output logic        is_jump2
);

   typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] pc_q;
   logic [31:0] hold_pc_q;
   logic        out_valid;
   logic        pend_q;
   logic [31:0] fetch_pc;
   logic [31:0] seq_pc;
   logic        consume;
   logic        slot_free;
   logic [31:0] word_lo;
   logic [31:0] word_hi;

   assign word_lo = imem_rdata[31:0];
   assign word_hi = imem_rdata[63:32];

   function automatic logic opcode_is_jump(input logic [6:0] opc);
      return (opc == 7'b1101111) || (opc == 7'b1100011);
   endfunction

   // Choose the next fetch PC: redirects from decode only apply when the current slots are being consumed this cycle
   always_comb begin
      consume   = out_valid & ~is_stall & ~fail;
      slot_free = ~out_valid | (~is_stall & ~fail);
      seq_pc    = IFpc1[2] ? (IFpc1 + 32'd4) : (IFpc1 + 32'd8);
      fetch_pc  = pc_q;
      if (consume) begin
         if (depend) begin
            fetch_pc = IFpc2;
         end else if (pre_branch1) begin
            fetch_pc = predict_pc1;
         end else if (pre_branch2) begin
            fetch_pc = predict_pc2;
         end else begin
            fetch_pc = seq_pc;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and memory request; DROP keeps presenting the abandoned address until memory answers it
   always_comb begin
      state_d   = state_q;
      imem_req  = 1'b0;
      imem_addr = {fetch_pc[31:3], 3'b000};
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            imem_req = slot_free | pend_q;
            if (fail && imem_req && !imem_ack) begin
               state_d = DROP;
            end
         end
         DROP: begin
            imem_req  = 1'b1;
            imem_addr = {hold_pc_q[31:3], 3'b000};
            if (imem_ack) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Slot outputs and fetch bookkeeping: flush on fail, load on ack, bubble when consumed slots are not refilled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         hold_pc_q <= RESET_PC;
         out_valid <= 1'b0;
         pend_q    <= 1'b0;
         ir1       <= NOP_INSN;
         ir2       <= NOP_INSN;
         IFpc1     <= 32'd0;
         IFpc2     <= 32'd0;
         is_jump1  <= 1'b0;
         is_jump2  <= 1'b0;
      end else if (fail) begin
         ir1       <= NOP_INSN;
         ir2       <= NOP_INSN;
         IFpc1     <= 32'd0;
         IFpc2     <= 32'd0;
         is_jump1  <= 1'b0;
         is_jump2  <= 1'b0;
         out_valid <= 1'b0;
         pend_q    <= 1'b0;
         pc_q      <= fail_pc;
         if (state_q == FETCH && imem_req && !imem_ack) begin
            hold_pc_q <= fetch_pc;
         end
      end else if (state_q == FETCH && imem_req) begin
         if (imem_ack) begin
            out_valid <= 1'b1;
            pend_q    <= 1'b0;
            IFpc1     <= fetch_pc;
            IFpc2     <= fetch_pc + 32'd4;
            if (!fetch_pc[2]) begin
               ir1      <= word_lo;
               ir2      <= word_hi;
               is_jump1 <= opcode_is_jump(word_lo[6:0]);
               is_jump2 <= opcode_is_jump(word_hi[6:0]);
               pc_q     <= fetch_pc + 32'd8;
            end else begin
               ir1      <= word_hi;
               ir2      <= NOP_INSN;
               is_jump1 <= opcode_is_jump(word_hi[6:0]);
               is_jump2 <= 1'b0;
               pc_q     <= fetch_pc + 32'd4;
            end
         end else begin
            pend_q <= 1'b1;
            pc_q   <= fetch_pc;
            if (consume) begin
               out_valid <= 1'b0;
               ir1       <= NOP_INSN;
               ir2       <= NOP_INSN;
               is_jump1  <= 1'b0;
               is_jump2  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dual_fetch.sv
// Testbench for dual_fetch: directed scenarios plus a randomized run
// checked against a transaction-level reference model of the fetch stage.
module tb_dual_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [63:0] imem_rdata;
   logic        is_stall = 1'b0;
   logic        depend = 1'b0;
   logic        pre_branch1 = 1'b0;
   logic        pre_branch2 = 1'b0;
   logic [31:0] predict_pc1 = 32'd0;
   logic [31:0] predict_pc2 = 32'd0;
   logic        fail = 1'b0;
   logic [31:0] fail_pc = 32'd0;
   logic [31:0] ir1;
   logic [31:0] ir2;
   logic [31:0] IFpc1;
   logic [31:0] IFpc2;
   logic        is_jump1;
   logic        is_jump2;

   int errors = 0;
   int checks = 0;
   int ack_delay = 0;
   int wait_cnt;

   // Reference model state
   bit          m_idle, m_drop, m_valid, m_pend, m_pcdef, m_j1, m_j2;
   logic [31:0] m_pc, m_drop_addr, m_ir1, m_ir2, m_pc1, m_pc2;
   // Per-cycle prediction and observation
   bit          p_req, adv;
   logic [31:0] p_target, p_addr;
   logic        o_req, o_ack;
   logic [31:0] o_addr;

   dual_fetch #(.RESET_PC(RPC), .NOP_INSN(NOP)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .is_stall(is_stall),
      .depend(depend), .pre_branch1(pre_branch1), .pre_branch2(pre_branch2),
      .predict_pc1(predict_pc1), .predict_pc2(predict_pc2), .fail(fail),
      .fail_pc(fail_pc), .ir1(ir1), .ir2(ir2), .IFpc1(IFpc1), .IFpc2(IFpc2),
      .is_jump1(is_jump1), .is_jump2(is_jump2));

   always #5 clk = ~clk;

   // Memory content is a pure function of the word address, with a mix of jump and non-jump opcodes
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [6:0] opc;
      case (a[4:2])
         3'd0: opc = 7'b0110011;
         3'd1: opc = 7'b1101111;
         3'd2: opc = 7'b0010011;
         3'd3: opc = 7'b1100011;
         3'd4: opc = 7'b0000011;
         3'd5: opc = 7'b0100011;
         3'd6: opc = 7'b1100011;
         default: opc = 7'b0110111;
      endcase
      return {a[26:2] ^ 25'h1555555, opc};
   endfunction

   function automatic logic isj(input logic [31:0] w);
      return (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100011);
   endfunction

   function automatic logic [31:0] rand_pc();
      if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFE0 + (32'($urandom_range(0, 7)) << 2);
      return 32'($urandom_range(0, 255)) << 2;
   endfunction

   // Memory answers a request once it has been waiting ack_delay cycles
   assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
   assign imem_rdata = {mem_word(imem_addr + 32'd4), mem_word(imem_addr)};

   // Memory wait counter, reset together with the fetch stage
   always @(posedge clk or posedge rst) begin
      if (rst) wait_cnt <= 0;
      else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   task automatic model_reset();
      m_idle = 1; m_drop = 0; m_valid = 0; m_pend = 0; m_pcdef = 1;
      m_pc = RPC; m_drop_addr = RPC;
      m_ir1 = NOP; m_ir2 = NOP; m_pc1 = 0; m_pc2 = 0; m_j1 = 0; m_j2 = 0;
   endtask

   task automatic model_predict();
      adv = 0;
      p_target = m_pc;
      if (m_idle) begin
         p_req = 0;
      end else if (m_drop) begin
         p_req = 1;
         p_target = m_drop_addr;
      end else begin
         adv = m_valid && !is_stall && !fail;
         if (adv) begin
            if (depend) p_target = m_pc2;
            else if (pre_branch1) p_target = predict_pc1;
            else if (pre_branch2) p_target = predict_pc2;
            else p_target = m_pc1 + (m_pc1[2] ? 32'd4 : 32'd8);
         end
         p_req = !m_valid || adv || m_pend;
      end
      p_addr = {p_target[31:3], 3'b000};
   endtask

   task automatic model_bubble();
      m_ir1 = NOP; m_ir2 = NOP; m_j1 = 0; m_j2 = 0;
   endtask

   task automatic model_update();
      if (m_idle) begin
         m_idle = 0;
      end else if (fail) begin
         if (m_drop) begin
            if (o_ack) m_drop = 0;
         end else if (p_req && !o_ack) begin
            m_drop = 1;
            m_drop_addr = p_target;
         end
         m_pc = fail_pc; m_pend = 0; m_valid = 0; m_pcdef = 1;
         model_bubble();
         m_pc1 = 0; m_pc2 = 0;
      end else if (m_drop) begin
         if (o_ack) m_drop = 0;
      end else if (p_req && o_ack) begin
         m_valid = 1; m_pend = 0; m_pcdef = 1;
         m_pc1 = p_target; m_pc2 = p_target + 32'd4;
         if (!p_target[2]) begin
            m_ir1 = mem_word(p_addr); m_ir2 = mem_word(p_addr + 32'd4);
            m_j1 = isj(m_ir1); m_j2 = isj(m_ir2);
         end else begin
            m_ir1 = mem_word(p_target); m_ir2 = NOP;
            m_j1 = isj(m_ir1); m_j2 = 0;
         end
      end else if (p_req) begin
         m_pend = 1;
         m_pc = p_target;
         if (adv) begin
            m_valid = 0; m_pcdef = 0;
            model_bubble();
         end
      end
   endtask

   // One clock: sample the request side at negedge, advance the model, settle after the posedge
   task automatic step();
      @(negedge clk);
      model_predict();
      o_req = imem_req; o_addr = imem_addr; o_ack = imem_ack;
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
      checks++; if (ir1 !== NOP || ir2 !== NOP) begin errors++; $display("[TB] FAIL reset_ir: got %h/%h expected %h", ir1, ir2, NOP); end
      checks++; if (IFpc1 !== 32'd0 || IFpc2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h/%h expected 0", IFpc1, IFpc2); end
      checks++; if (is_jump1 !== 1'b0 || is_jump2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_jump: got %b%b expected 00", is_jump1, is_jump2); end
      rst = 1'b0;
      step();
      checks++; if (o_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req: got %b expected 0", o_req); end
   endtask

   task automatic test_sequential();
      logic [31:0] e;
      for (int i = 0; i < 5; i++) begin
         step();
         e = RPC + 32'(8 * i);
         checks++; if (o_req !== 1'b1 || o_addr !== e) begin errors++; $display("[TB] FAIL seq_addr: got %b/%h expected 1/%h", o_req, o_addr, e); end
         checks++; if (ir1 !== mem_word(e) || ir2 !== mem_word(e + 32'd4)) begin errors++; $display("[TB] FAIL seq_ir: got %h/%h expected %h/%h", ir1, ir2, mem_word(e), mem_word(e + 32'd4)); end
         checks++; if (IFpc1 !== e || IFpc2 !== e + 32'd4) begin errors++; $display("[TB] FAIL seq_pc: got %h/%h expected %h/%h", IFpc1, IFpc2, e, e + 32'd4); end
         checks++; if (is_jump1 !== isj(mem_word(e)) || is_jump2 !== isj(mem_word(e + 32'd4))) begin errors++; $display("[TB] FAIL seq_jump: got %b%b expected %b%b", is_jump1, is_jump2, isj(mem_word(e)), isj(mem_word(e + 32'd4))); end
      end
   endtask

   task automatic test_depend();
      pre_branch1 = 1; predict_pc1 = 32'h100;
      step();
      pre_branch1 = 0;
      checks++; if (IFpc1 !== 32'h100) begin errors++; $display("[TB] FAIL dep_setup: got %h expected 00000100", IFpc1); end
      depend = 1;
      step();
      depend = 0;
      checks++; if (o_addr !== 32'h100) begin errors++; $display("[TB] FAIL dep_addr: got %h expected 00000100", o_addr); end
      checks++; if (ir1 !== mem_word(32'h104) || ir2 !== NOP) begin errors++; $display("[TB] FAIL dep_ir: got %h/%h expected %h/%h", ir1, ir2, mem_word(32'h104), NOP); end
      checks++; if (IFpc1 !== 32'h104 || IFpc2 !== 32'h108 || is_jump2 !== 1'b0) begin errors++; $display("[TB] FAIL dep_pc: got %h/%h/%b expected 00000104/00000108/0", IFpc1, IFpc2, is_jump2); end
      step();
      checks++; if (o_addr !== 32'h108 || IFpc1 !== 32'h108) begin errors++; $display("[TB] FAIL dep_next: got %h/%h expected 00000108", o_addr, IFpc1); end
   endtask

   task automatic test_branch();
      pre_branch1 = 1; predict_pc1 = 32'h200; pre_branch2 = 1; predict_pc2 = 32'h300;
      step();
      checks++; if (o_addr !== 32'h200 || IFpc1 !== 32'h200) begin errors++; $display("[TB] FAIL br1_addr: got %h/%h expected 00000200", o_addr, IFpc1); end
      pre_branch1 = 0;
      step();
      pre_branch2 = 0;
      checks++; if (o_addr !== 32'h300 || IFpc1 !== 32'h300) begin errors++; $display("[TB] FAIL br2_addr: got %h/%h expected 00000300", o_addr, IFpc1); end
   endtask

   task automatic test_stall();
      pre_branch1 = 1; predict_pc1 = 32'h240;
      step();
      pre_branch1 = 0;
      is_stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (o_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b expected 0", o_req); end
         checks++; if (IFpc1 !== 32'h240 || ir1 !== mem_word(32'h240) || ir2 !== mem_word(32'h244)) begin errors++; $display("[TB] FAIL stall_hold: got %h %h/%h expected 00000240 %h/%h", IFpc1, ir1, ir2, mem_word(32'h240), mem_word(32'h244)); end
      end
      is_stall = 0;
      step();
      checks++; if (o_req !== 1'b1 || o_addr !== 32'h248) begin errors++; $display("[TB] FAIL stall_resume: got %b/%h expected 1/00000248", o_req, o_addr); end
   endtask

   task automatic test_wrap();
      pre_branch1 = 1; predict_pc1 = 32'hFFFF_FFF8;
      step();
      pre_branch1 = 0;
      step();
      checks++; if (o_addr !== 32'h0 || IFpc1 !== 32'h0) begin errors++; $display("[TB] FAIL wrap8: got %h/%h expected 0", o_addr, IFpc1); end
      pre_branch1 = 1; predict_pc1 = 32'hFFFF_FFFC;
      step();
      pre_branch1 = 0;
      checks++; if (o_addr !== 32'hFFFF_FFF8 || IFpc2 !== 32'h0 || ir2 !== NOP) begin errors++; $display("[TB] FAIL wrap4_slot: got %h/%h/%h expected fffffff8/0/%h", o_addr, IFpc2, ir2, NOP); end
      step();
      checks++; if (o_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap4_next: got %h expected 0", o_addr); end
   endtask

   task automatic test_fail_ack();
      ack_delay = 1;
      step();
      checks++; if (o_addr !== 32'h8 || ir1 !== NOP || ir2 !== NOP) begin errors++; $display("[TB] FAIL fa_bubble: got %h %h/%h expected 00000008 %h", o_addr, ir1, ir2, NOP); end
      fail = 1; fail_pc = 32'h480;
      step();
      fail = 0;
      checks++; if (ir1 !== NOP || IFpc1 !== 32'h0) begin errors++; $display("[TB] FAIL fa_discard: got %h/%h expected %h/0", ir1, IFpc1, NOP); end
      step();
      checks++; if (o_req !== 1'b1 || o_addr !== 32'h480) begin errors++; $display("[TB] FAIL fa_restart: got %b/%h expected 1/00000480", o_req, o_addr); end
      step();
      checks++; if (ir1 !== mem_word(32'h480) || IFpc1 !== 32'h480) begin errors++; $display("[TB] FAIL fa_load: got %h/%h expected %h/00000480", ir1, IFpc1, mem_word(32'h480)); end
      ack_delay = 0;
   endtask

   task automatic test_fail_drop();
      pre_branch1 = 1; predict_pc1 = 32'h300;
      step();
      pre_branch1 = 0;
      ack_delay = 2;
      step();
      checks++; if (o_addr !== 32'h308 || ir1 !== NOP) begin errors++; $display("[TB] FAIL fd_pend: got %h/%h expected 00000308/%h", o_addr, ir1, NOP); end
      fail = 1; fail_pc = 32'h400;
      step();
      fail = 0;
      checks++; if (ir1 !== NOP || IFpc1 !== 32'h0) begin errors++; $display("[TB] FAIL fd_flush: got %h/%h expected %h/0", ir1, IFpc1, NOP); end
      step();
      checks++; if (o_req !== 1'b1 || o_addr !== 32'h308) begin errors++; $display("[TB] FAIL fd_hold: got %b/%h expected 1/00000308", o_req, o_addr); end
      checks++; if (ir1 !== NOP || ir2 !== NOP) begin errors++; $display("[TB] FAIL fd_discard: got %h/%h expected %h", ir1, ir2, NOP); end
      step();
      checks++; if (o_req !== 1'b1 || o_addr !== 32'h400) begin errors++; $display("[TB] FAIL fd_restart: got %b/%h expected 1/00000400", o_req, o_addr); end
      repeat (2) step();
      checks++; if (ir1 !== mem_word(32'h400) || IFpc1 !== 32'h400) begin errors++; $display("[TB] FAIL fd_load: got %h/%h expected %h/00000400", ir1, IFpc1, mem_word(32'h400)); end
   endtask

   task automatic test_fail_in_drop();
      ack_delay = 3;
      step();
      fail = 1; fail_pc = 32'h500;
      step();
      fail_pc = 32'h600;
      step();
      fail = 0;
      checks++; if (o_addr !== 32'h408) begin errors++; $display("[TB] FAIL fid_hold: got %h expected 00000408", o_addr); end
      step();
      ack_delay = 0;
      step();
      checks++; if (o_addr !== 32'h600 || ir1 !== mem_word(32'h600)) begin errors++; $display("[TB] FAIL fid_newest: got %h/%h expected 00000600/%h", o_addr, ir1, mem_word(32'h600)); end
   endtask

   task automatic test_reset_drop();
      ack_delay = 3;
      step();
      fail = 1; fail_pc = 32'h700;
      step();
      fail = 0;
      do_reset();
      checks++; if (imem_req !== 1'b0 || ir1 !== NOP || ir2 !== NOP) begin errors++; $display("[TB] FAIL rd_reset: got %b %h/%h expected 0 %h", imem_req, ir1, ir2, NOP); end
      rst = 1'b0;
      ack_delay = 0;
      step();
      checks++; if (o_req !== 1'b0) begin errors++; $display("[TB] FAIL rd_idle: got %b expected 0", o_req); end
      step();
      checks++; if (o_req !== 1'b1 || o_addr !== RPC) begin errors++; $display("[TB] FAIL rd_first: got %b/%h expected 1/%h", o_req, o_addr, RPC); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         is_stall    = ($urandom_range(0, 99) < 25);
         depend      = ($urandom_range(0, 99) < 15);
         pre_branch1 = ($urandom_range(0, 99) < 15);
         pre_branch2 = ($urandom_range(0, 99) < 15);
         predict_pc1 = rand_pc();
         predict_pc2 = rand_pc();
         fail        = ($urandom_range(0, 99) < 6);
         fail_pc     = rand_pc();
         ack_delay   = $urandom_range(0, 2);
         step();
         checks++; if (o_req !== p_req) begin errors++; $display("[TB] FAIL rnd_req c=%0d: got %b expected %b", c, o_req, p_req); end
         if (p_req) begin
            checks++; if (o_addr !== p_addr) begin errors++; $display("[TB] FAIL rnd_addr c=%0d: got %h expected %h", c, o_addr, p_addr); end
         end
         checks++; if (ir1 !== m_ir1 || ir2 !== m_ir2) begin errors++; $display("[TB] FAIL rnd_ir c=%0d: got %h/%h expected %h/%h", c, ir1, ir2, m_ir1, m_ir2); end
         checks++; if (is_jump1 !== m_j1 || is_jump2 !== m_j2) begin errors++; $display("[TB] FAIL rnd_jump c=%0d: got %b%b expected %b%b", c, is_jump1, is_jump2, m_j1, m_j2); end
         if (m_pcdef) begin
            checks++; if (IFpc1 !== m_pc1 || IFpc2 !== m_pc2) begin errors++; $display("[TB] FAIL rnd_pc c=%0d: got %h/%h expected %h/%h", c, IFpc1, IFpc2, m_pc1, m_pc2); end
         end
      end
      is_stall = 0; depend = 0; pre_branch1 = 0; pre_branch2 = 0; fail = 0; ack_delay = 0;
   endtask

   initial begin
      $display("[TB] dual_fetch bench starting");
      test_reset();
      test_sequential();
      test_depend();
      test_branch();
      test_stall();
      test_wrap();
      test_fail_ack();
      test_fail_drop();
      test_fail_in_drop();
      test_reset_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dual_fetch.md
DUAL_FETCH -- requirements
Module: dual_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSN, default 32'h0000_0013, is the instruction word driven in empty or killed slots.
REQ-003 clk  input  1  is the single clock; all state updates on its posedge.
REQ-004 rst  input  1  is the reset; asynchronous and active-high.
REQ-005 imem_req  output  1  is the fetch request to instruction memory.
REQ-006 imem_addr  output  32  is the byte address of the 8-byte-aligned fetch block, {pc[31:3],3'b0}.
REQ-007 imem_ack  input  1  indicates imem_rdata is valid this cycle for the presented request.
REQ-008 imem_rdata  input  64  is the fetch block; [31:0] at +0 and [63:32] at +4.
REQ-009 is_stall, depend, pre_branch1, pre_branch2  input  1 each  are the current-cycle controls from the downstream decode stage.
REQ-010 predict_pc1, predict_pc2  input  32 each  are the predicted targets for slots 1 and 2.
REQ-011 fail, fail_pc  input  1/32  are the mispredict flush and the correct restart PC.
REQ-012 ir1, ir2  output  32 each  are the registered slot instructions.
REQ-013 IFpc1, IFpc2  output  32 each  are the registered slot PCs.
REQ-014 is_jump1, is_jump2  output  1 each  are high when the slot opcode[6:0] is 7'b1101111 (JAL) or 7'b1100011 (BRANCH).

Function
REQ-015 The block SHALL implement states IDLE, FETCH and DROP; IDLE lasts exactly one cycle after reset deassertion, then goes to FETCH.
REQ-016 Internal regs: pc_q (next fetch PC), out_valid, pend_q (request issued without ack).
REQ-017 slot_free SHALL equal !out_valid | (!is_stall & !fail) in FETCH.
REQ-018 imem_req SHALL be high in FETCH when slot_free or pend_q, and high in DROP; it SHALL be low in IDLE.
REQ-019 When out_valid & !is_stall & !fail, fetch PC SHALL be, in priority order: depend -> IFpc2; pre_branch1 -> predict_pc1; pre_branch2 -> predict_pc2; otherwise IFpc1+8 if IFpc1[2]==0, else IFpc1+4. Otherwise fetch PC SHALL be pc_q.
REQ-020 imem_addr SHALL derive from the fetch PC, and SHALL stay stable while imem_req is high and imem_ack is low.
REQ-021 On imem_ack in FETCH with !fail, at posedge: if pc[2]==0, ir1=rdata[31:0], ir2=rdata[63:32], IFpc1=pc, IFpc2=pc+4; if pc[2]==1, ir1=rdata[63:32], ir2=NOP_INSN, IFpc1=pc, IFpc2=pc+4, is_jump2=0. out_valid SHALL be set.
REQ-022 A request with no ack SHALL set pend_q and latch the fetch PC into pc_q; out_valid SHALL clear if the outputs were consumed.
REQ-023 While is_stall & out_valid & !fail, all outputs SHALL hold and no new request SHALL issue.
REQ-024 When fail is high, outputs SHALL become NOP_INSN, PCs 0, is_jump 0, out_valid 0, and pc_q SHALL load fail_pc.
REQ-025 If fail coincides with imem_ack, the returned data SHALL be discarded and the state SHALL stay FETCH.
REQ-026 If fail arrives with pend_q high and no ack, the state SHALL go to DROP.
REQ-027 In DROP, the old address SHALL be held until ack, the data discarded, then the state SHALL return to FETCH at fail_pc.
REQ-028 If fail arrives while already in DROP, pc_q SHALL update to the newest fail_pc.
REQ-029 Fetch PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFF8 to 0 SHALL be silent.
REQ-030 If out_valid is 0, ir1/ir2 SHALL be NOP_INSN, so that downstream sees a bubble.

Reset
REQ-031 While rst is high: state=IDLE, pc_q=RESET_PC, out_valid=0, pend_q=0, ir1=ir2=NOP_INSN, IFpc1=IFpc2=0, is_jump1=is_jump2=0, imem_req=0.
REQ-032 Reset asserted mid-request SHALL abandon it; memory is reset in the same domain.

Verification
REQ-033 Reset, zero-wait ack, no controls -> imem_addr 0,8,16,... on consecutive cycles; ir1/ir2 carry both words; IFpc2=IFpc1+4.
REQ-034 depend=1 with IFpc1=0x100 -> next fetch 0x104; ir1=rdata[63:32] of block 0x100, ir2=NOP_INSN; following fetch 0x108.
REQ-035 pre_branch1=1, predict_pc1=0x200 with pre_branch2 also high -> next imem_addr 0x200; predict_pc2 ignored.
REQ-036 is_stall held 3 cycles -> outputs constant, imem_req low; release -> fetch resumes at the sequential PC.
REQ-037 fail=1, fail_pc=0x400 while a request is pending and ack is delayed 2 cycles -> DROP; old data not output; next request at 0x400.
REQ-038 rst pulse during DROP -> IDLE, outputs NOP_INSN, first request at RESET_PC.
